// File: rtl/bomb_defuse_controller_if.sv
// Signal bundle between the defuse controller, the player inputs and the code comparator.
interface bomb_defuse_controller_if;
    logic       arm;
    logic [2:0] code_set;
    logic [2:0] guess;
    logic       submit;
    logic       cmp_s;
    logic [2:0] cmp_q1;
    logic [2:0] cmp_q2;
    logic       cmp_enable;
    logic       armed;
    logic       defused;
    logic       exploded;
    logic       wrong;
    logic [7:0] seconds_left;
    logic [1:0] attempts_left;

    // Player/comparator side: drives the controls and comparator result.
    modport master (
        output arm, code_set, guess, submit, cmp_s,
        input  cmp_q1, cmp_q2, cmp_enable, armed, defused, exploded, wrong,
               seconds_left, attempts_left
    );

    // Controller side.
    modport slave (
        input  arm, code_set, guess, submit, cmp_s,
        output cmp_q1, cmp_q2, cmp_enable, armed, defused, exploded, wrong,
               seconds_left, attempts_left
    );
endinterface

// File: rtl/bomb_defuse_controller.sv
// Game sequencer for the time bomb: latches the secret, counts down seconds, steps each
// guess through the external comparator and resolves to DEFUSED or EXPLODED.
module bomb_defuse_controller #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TIMEOUT_SEC   = 60,
    parameter int unsigned MAX_ATTEMPTS  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    bomb_defuse_controller_if.slave     bus_io
);
    localparam int unsigned PW = $clog2(TICKS_PER_SEC);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StArmed    = 3'd1;
    localparam logic [2:0] StCheck    = 3'd2;
    localparam logic [2:0] StDefused  = 3'd3;
    localparam logic [2:0] StExploded = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    q1_q, q1_d;
    logic [2:0]    q2_q, q2_d;
    logic [7:0]    sec_q, sec_d;
    logic [1:0]    att_q, att_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          wrong_q, wrong_d;
    logic          armed_q, armed_d;
    logic          defused_q, defused_d;
    logic          exploded_q, exploded_d;
    logic          tick;
    logic          expire;

    assign tick   = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign expire = tick && (sec_q == 8'd1);

    // Next-state: game FSM, countdown and the latched comparator operands.
    always_comb begin
        state_d = state_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        sec_d   = sec_q;
        att_d   = att_q;
        presc_d = presc_q;
        wrong_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.arm) begin
                    state_d = StArmed;
                    q1_d    = bus_io.code_set;
                    sec_d   = 8'(TIMEOUT_SEC);
                    att_d   = 2'(MAX_ATTEMPTS);
                    presc_d = '0;
                end
            end
            StArmed, StCheck: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick && sec_q != 8'd0) begin
                    sec_d = sec_q - 8'd1;
                end
                if (state_q == StArmed) begin
                    if (expire) begin
                        state_d = StExploded;
                    end else if (bus_io.submit) begin
                        state_d = StCheck;
                        q2_d    = bus_io.guess;
                    end
                end else begin
                    // A matching verdict beats a timeout landing on the same edge.
                    if (bus_io.cmp_s) begin
                        state_d = StDefused;
                    end else begin
                        wrong_d = 1'b1;
                        att_d   = (att_q > 2'd1) ? att_q - 2'd1 : 2'd0;
                        state_d = (att_q > 2'd1 && !expire) ? StArmed : StExploded;
                    end
                end
            end
            StDefused, StExploded: ;
            default: state_d = StIdle;
        endcase
    end

    // Status flags are registered from the next state so they line up with the FSM.
    always_comb begin
        armed_d    = (state_d == StArmed) || (state_d == StCheck);
        defused_d  = (state_d == StDefused);
        exploded_d = (state_d == StExploded);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            q1_q       <= '0;
            q2_q       <= '0;
            sec_q      <= '0;
            att_q      <= '0;
            presc_q    <= '0;
            wrong_q    <= 1'b0;
            armed_q    <= 1'b0;
            defused_q  <= 1'b0;
            exploded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            sec_q      <= sec_d;
            att_q      <= att_d;
            presc_q    <= presc_d;
            wrong_q    <= wrong_d;
            armed_q    <= armed_d;
            defused_q  <= defused_d;
            exploded_q <= exploded_d;
        end
    end

    // Output drive; cmp_enable is the only decoded (unregistered) output.
    always_comb begin
        bus_io.cmp_q1        = q1_q;
        bus_io.cmp_q2        = q2_q;
        bus_io.cmp_enable    = (state_q == StCheck);
        bus_io.armed         = armed_q;
        bus_io.defused       = defused_q;
        bus_io.exploded      = exploded_q;
        bus_io.wrong         = wrong_q;
        bus_io.seconds_left  = sec_q;
        bus_io.attempts_left = att_q;
    end
endmodule

// File: tb/tb_bomb_defuse_controller.sv
// Directed bench for bomb_defuse_controller with TICKS_PER_SEC=4, TIMEOUT_SEC=3, MAX_ATTEMPTS=3.
module tb_bomb_defuse_controller;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    bomb_defuse_controller_if bus ();

    bomb_defuse_controller #(
        .TICKS_PER_SEC (4),
        .TIMEOUT_SEC   (3),
        .MAX_ATTEMPTS  (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Combinational model of the 3-bit comparator.
    assign bus.cmp_s = bus.cmp_enable && (bus.cmp_q1 == bus.cmp_q2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        step();
    endtask

    task automatic arm_with(input logic [2:0] code);
        bus.arm      = 1'b1;
        bus.code_set = code;
        step();
        bus.arm      = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".armed"},    32'(bus.armed),         32'd0);
        check({tag, ".defused"},  32'(bus.defused),       32'd0);
        check({tag, ".exploded"}, 32'(bus.exploded),      32'd0);
        check({tag, ".wrong"},    32'(bus.wrong),         32'd0);
        check({tag, ".enable"},   32'(bus.cmp_enable),    32'd0);
        check({tag, ".q1"},       32'(bus.cmp_q1),        32'd0);
        check({tag, ".q2"},       32'(bus.cmp_q2),        32'd0);
        check({tag, ".sec"},      32'(bus.seconds_left),  32'd0);
        check({tag, ".att"},      32'(bus.attempts_left), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b1;
        bus.arm      = 1'b0;
        bus.code_set = 3'd0;
        bus.guess    = 3'd0;
        bus.submit   = 1'b0;
        #2;

        // Reset state, then timeout explosion.
        do_reset();
        check_idle("rst");
        arm_with(3'b101);
        check("arm.armed", 32'(bus.armed),         32'd1);
        check("arm.sec",   32'(bus.seconds_left),  32'd3);
        check("arm.att",   32'(bus.attempts_left), 32'd3);
        check("arm.q1",    32'(bus.cmp_q1),        32'd5);
        step(3);
        check("to.sec_e3", 32'(bus.seconds_left),  32'd3);
        step();
        check("to.sec_e4", 32'(bus.seconds_left),  32'd2);
        step(4);
        check("to.sec_e8", 32'(bus.seconds_left),  32'd1);
        step(3);
        check("to.expl_e11", 32'(bus.exploded),    32'd0);
        step();
        check("to.expl_e12", 32'(bus.exploded),    32'd1);
        check("to.armed",    32'(bus.armed),       32'd0);
        check("to.sec0",     32'(bus.seconds_left), 32'd0);
        step(5);
        check("to.sec_hold", 32'(bus.seconds_left), 32'd0);
        check("to.expl_hold", 32'(bus.exploded),   32'd1);

        // Correct guess defuses with two-cycle latency.
        do_reset();
        arm_with(3'b101);
        step();
        bus.submit = 1'b1;
        bus.guess  = 3'b101;
        step();
        bus.submit = 1'b0;
        check("def.enable",  32'(bus.cmp_enable),  32'd1);
        check("def.q2",      32'(bus.cmp_q2),      32'd5);
        check("def.early",   32'(bus.defused),     32'd0);
        step();
        check("def.defused", 32'(bus.defused),     32'd1);
        check("def.armed",   32'(bus.armed),       32'd0);
        check("def.enable0", 32'(bus.cmp_enable),  32'd0);
        check("def.sec",     32'(bus.seconds_left), 32'd3);
        step(6);
        check("def.sec_frz", 32'(bus.seconds_left), 32'd3);
        check("def.hold",    32'(bus.defused),     32'd1);

        // Three wrong guesses, back-to-back on the wrong pulse.
        do_reset();
        arm_with(3'b101);
        bus.submit = 1'b1;
        bus.guess  = 3'b000;
        step();
        bus.submit = 1'b0;
        step();
        check("w1.wrong", 32'(bus.wrong),         32'd1);
        check("w1.att",   32'(bus.attempts_left), 32'd2);
        check("w1.armed", 32'(bus.armed),         32'd1);
        bus.submit = 1'b1;
        bus.guess  = 3'b111;
        step();
        bus.submit = 1'b0;
        check("w2.enable", 32'(bus.cmp_enable),   32'd1);
        check("w2.wrong0", 32'(bus.wrong),        32'd0);
        step();
        check("w2.wrong", 32'(bus.wrong),         32'd1);
        check("w2.att",   32'(bus.attempts_left), 32'd1);
        bus.submit = 1'b1;
        bus.guess  = 3'b010;
        step();
        bus.submit = 1'b0;
        step();
        check("w3.wrong", 32'(bus.wrong),         32'd1);
        check("w3.att",   32'(bus.attempts_left), 32'd0);
        check("w3.expl",  32'(bus.exploded),      32'd1);
        check("w3.armed", 32'(bus.armed),         32'd0);
        bus.submit = 1'b1;
        bus.guess  = 3'b101;
        step();
        bus.submit = 1'b0;
        step();
        check("w4.defused", 32'(bus.defused),    32'd0);
        check("w4.expl",    32'(bus.exploded),   32'd1);
        check("w4.q2",      32'(bus.cmp_q2),     32'd2);
        check("w4.wrong",   32'(bus.wrong),      32'd0);

        // Defuse on the same edge as the final decrement.
        do_reset();
        arm_with(3'b101);
        step(10);
        bus.submit = 1'b1;
        bus.guess  = 3'b101;
        step();
        bus.submit = 1'b0;
        check("race.enable", 32'(bus.cmp_enable),  32'd1);
        check("race.sec",    32'(bus.seconds_left), 32'd1);
        step();
        check("race.defused", 32'(bus.defused),    32'd1);
        check("race.expl",    32'(bus.exploded),   32'd0);

        // Submit during CHECK and arm while ARMED are ignored.
        do_reset();
        arm_with(3'b101);
        bus.submit = 1'b1;
        bus.guess  = 3'b011;
        step();
        bus.guess    = 3'b101;
        bus.arm      = 1'b1;
        bus.code_set = 3'b010;
        step();
        bus.submit = 1'b0;
        check("ign.q2",     32'(bus.cmp_q2),        32'd3);
        check("ign.wrong",  32'(bus.wrong),         32'd1);
        check("ign.att",    32'(bus.attempts_left), 32'd2);
        check("ign.enable", 32'(bus.cmp_enable),    32'd0);
        step();
        bus.arm = 1'b0;
        check("ign.q1",     32'(bus.cmp_q1),        32'd5);
        check("ign.sec",    32'(bus.seconds_left),  32'd3);
        check("ign.armed",  32'(bus.armed),         32'd1);
        check("ign.enable2", 32'(bus.cmp_enable),   32'd0);
        step();
        check("ign.sec_dec", 32'(bus.seconds_left), 32'd2);

        // Asynchronous reset in the middle of CHECK.
        do_reset();
        arm_with(3'b101);
        bus.submit = 1'b1;
        bus.guess  = 3'b101;
        step();
        bus.submit = 1'b0;
        check("ar.enable", 32'(bus.cmp_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("ar");
        #13;
        rst_n = 1'b1;
        bus.submit = 1'b1;
        bus.guess  = 3'b110;
        step();
        bus.submit = 1'b0;
        check("ar.idle_armed",  32'(bus.armed),      32'd0);
        check("ar.idle_enable", 32'(bus.cmp_enable), 32'd0);
        check("ar.idle_q2",     32'(bus.cmp_q2),     32'd0);
        arm_with(3'b110);
        check("ar.rearm",   32'(bus.armed),         32'd1);
        check("ar.q1",      32'(bus.cmp_q1),        32'd6);
        check("ar.sec",     32'(bus.seconds_left),  32'd3);
        check("ar.att",     32'(bus.attempts_left), 32'd3);
        bus.submit = 1'b1;
        bus.guess  = 3'b110;
        step();
        bus.submit = 1'b0;
        step();
        check("ar.defused", 32'(bus.defused),       32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bomb_defuse_controller.md
# bomb_defuse_controller

Sequencing controller for the 3-bit code comparator in the time-bomb design. Latches a secret code on arming, runs a seconds countdown, accepts player guesses and drives the comparator's q1/q2/enable inputs for one cycle per guess. Resolves each game to DEFUSED or EXPLODED and exports timer, attempt and status signals to the display and LED logic.

## Interface
- TICKS_PER_SEC, default 50_000_000: clk cycles per countdown second; must be ≥2.
- TIMEOUT_SEC, default 60: initial seconds_left; range 1..255.
- MAX_ATTEMPTS, default 3: wrong guesses allowed before explosion; range 1..3.

- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle pulse; starts the game from IDLE.
- code_set  in  3  secret code; sampled on the arm cycle.
- guess  in  3  player code; sampled on the submit cycle.
- submit  in  1  one-cycle pulse; presents guess.
- cmp_s  in  1  comparator result s.
- cmp_q1  out  3  to comparator q1: latched secret.
- cmp_q2  out  3  to comparator q2: latched guess.
- cmp_enable  out  1  to comparator enable.
- armed  out  1  high in ARMED and CHECK.
- defused  out  1  high in DEFUSED.
- exploded  out  1  high in EXPLODED.
- wrong  out  1  one-cycle pulse per mismatched guess.
- seconds_left  out  8  remaining seconds.
- attempts_left  out  2  remaining wrong guesses allowed.

## Operation
- States: IDLE, ARMED, CHECK, DEFUSED, EXPLODED. All outputs registered, except cmp_enable, which is a decode of state == CHECK.
- Reset values: state IDLE; cmp_q1 = cmp_q2 = 0; cmp_enable = armed = defused = exploded = wrong = 0; seconds_left = 0; attempts_left = 0; prescaler = 0.
- IDLE: arm=1 → ARMED. Same edge: cmp_q1 ← code_set, seconds_left ← TIMEOUT_SEC, attempts_left ← MAX_ATTEMPTS, prescaler ← 0. submit is ignored.
- ARMED: submit=1 → CHECK, cmp_q2 ← guess. arm is ignored.
- CHECK (exactly 1 cycle): cmp_enable=1; cmp_s is sampled at the closing edge.
  - cmp_s=1 → DEFUSED.
  - cmp_s=0 and attempts_left>1 → ARMED, attempts_left−1, wrong=1 for 1 cycle.
  - cmp_s=0 and attempts_left==1 → EXPLODED, attempts_left ← 0, wrong=1 for 1 cycle.
  - submit and arm are ignored.
- Countdown runs only in ARMED and CHECK.
  - Prescaler counts 0..TICKS_PER_SEC−1 and wraps.
  - On wrap, seconds_left−1.
  - If seconds_left goes 1→0, next state is EXPLODED.
- DEFUSED and EXPLODED are terminal; only rst_n exits them. seconds_left and attempts_left freeze at their final values.
- Priority when expiry and a CHECK result fall on the same edge: cmp_s=1 → DEFUSED (defuse wins). A mismatch → EXPLODED.
- Prescaler width is $clog2(TICKS_PER_SEC). seconds_left never underflows below 0.
- rst_n asserted in any state, mid-CHECK included: all registers take reset values immediately, with no clock required.

## Timing
- arm sampled at edge E: armed=1 and seconds_left=TIMEOUT_SEC after E.
- First decrement occurs TICKS_PER_SEC edges after E. Explosion by timeout occurs TIMEOUT_SEC×TICKS_PER_SEC edges after E.
- submit sampled at edge S: cmp_enable=1 during the cycle after S. The verdict (defused, exploded or wrong) is visible after edge S+1, i.e. 2-cycle latency.
- A submit in the cycle where wrong=1 is accepted, since the state is already ARMED.
- armed deasserts on the same edge that defused or exploded asserts.
- Release of rst_n is assumed synchronised upstream; the first active edge after release behaves as in IDLE.

## Test plan
Parameters: TICKS_PER_SEC=4, TIMEOUT_SEC=3, MAX_ATTEMPTS=3. The bench models the comparator combinationally.
- Reset then arm with code_set=3'b101 → armed=1, seconds_left=3, attempts_left=3, cmp_q1=3'b101. Idle thereafter → seconds_left goes 2, 1 at +4 and +8 cycles; exploded=1 at +12 cycles.
- Arm with 3'b101, submit guess=3'b101 → cmp_enable=1 for 1 cycle; defused=1 two edges after submit; seconds_left frozen.
- Arm, then submit 3'b000, 3'b111, 3'b010 → wrong pulses; attempts_left 2, 1, 0; exploded=1 after the third verdict. A later submit 3'b101 is ignored.
- Submit the correct code so CHECK's closing edge coincides with the 1→0 decrement → defused=1, exploded=0.
- Pulse submit during CHECK and arm while ARMED → no effect. cmp_q2 holds the first guess; seconds_left is not reloaded.
- Assert rst_n=0 mid-CHECK, asynchronously between edges → all outputs go to reset values at once; state IDLE after release; a new arm works normally.
